// File: rtl/morph3x3_stream.sv
// -----------------------------------------------------------------------------
// morph3x3_stream
// Streaming 3x3 morphological operator (erode / dilate / gradient / pass).
// Two lines are buffered internally and a 3x3 window slides over the raster.
// One result is produced for every interior pixel, so the output frame is
// (IMG_W-2) x (IMG_H-2). The output framing matches the input framing, which
// lets two instances be chained back to back (erode then dilate = opening).
//
// Ports
//   lcd_pclk   clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input pixel qualifier (always accepted, no backpressure)
//   in_sof     first pixel of frame, qualified by in_valid
//   in_data    pixel, channel k at [k*CH_W +: CH_W]
//   mode       00 pass, 01 erode, 10 dilate, 11 gradient (latched on in_sof)
//   out_valid  result pixel qualifier (one pulse per interior pixel)
//   out_data   result pixel
//   out_sof    first result pixel of frame
//   out_eol    last result pixel of a line
//   out_eof    last result pixel of frame
//   err        sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
module morph3x3_stream #(
    parameter int unsigned CH_N  = 3,
    parameter int unsigned CH_W  = 8,
    parameter int unsigned IMG_W = 250,
    parameter int unsigned IMG_H = 250
) (
    input  logic                   lcd_pclk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic [CH_N*CH_W-1:0]   in_data,
    input  logic [1:0]             mode,
    output logic                   out_valid,
    output logic [CH_N*CH_W-1:0]   out_data,
    output logic                   out_sof,
    output logic                   out_eol,
    output logic                   out_eof,
    output logic                   err
);

    localparam int unsigned PIX_W  = CH_N * CH_W;
    localparam int unsigned CNT_W  = 11;
    localparam int unsigned ADDR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [1:0] MODE_PASS   = 2'b00;
    localparam logic [1:0] MODE_ERODE  = 2'b01;
    localparam logic [1:0] MODE_DILATE = 2'b10;
    localparam logic [1:0] MODE_GRAD   = 2'b11;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   col;
    logic [CNT_W-1:0]   row;
    logic [1:0]         mode_q;

    // Line buffers: lb0 holds the previous line, lb1 the line before that.
    logic [PIX_W-1:0]   lb0 [IMG_W];
    logic [PIX_W-1:0]   lb1 [IMG_W];

    // Window columns: index 0 is the oldest (left), index 2 the newest (right).
    logic [PIX_W-1:0]   w_top [3];
    logic [PIX_W-1:0]   w_mid [3];
    logic [PIX_W-1:0]   w_bot [3];

    // Window-valid stage, registered alongside the window shift.
    logic               win_vld;
    logic               win_sof;
    logic               win_eol;
    logic               win_eof;

    logic               take_c;
    logic               start_c;
    logic [CNT_W-1:0]   pos_col_c;
    logic [CNT_W-1:0]   pos_row_c;
    logic               last_col_c;
    logic               last_pix_c;
    logic               win_ok_c;
    logic [ADDR_W-1:0]  addr_c;
    logic [PIX_W-1:0]   lb_top_c;
    logic [PIX_W-1:0]   lb_mid_c;

    logic [PIX_W-1:0]   taps_c   [9];
    logic [CH_W-1:0]    ch_min_c [CH_N];
    logic [CH_W-1:0]    ch_max_c [CH_N];
    logic [PIX_W-1:0]   op_data_c;

    // Position of the pixel being accepted; an in_sof pixel is always (0,0).
    always_comb begin
        start_c    = in_valid && in_sof;
        take_c     = in_valid && (in_sof || (state == ACTIVE));
        pos_col_c  = start_c ? '0 : col;
        pos_row_c  = start_c ? '0 : row;
        last_col_c = (pos_col_c == CNT_W'(IMG_W - 1));
        last_pix_c = last_col_c && (pos_row_c == CNT_W'(IMG_H - 1));
        win_ok_c   = take_c && (pos_row_c >= CNT_W'(2)) && (pos_col_c >= CNT_W'(2));
        addr_c     = ADDR_W'(pos_col_c);
        lb_top_c   = lb1[addr_c];
        lb_mid_c   = lb0[addr_c];
    end

    // Line buffer update: the previous line ages into lb1, the new pixel into lb0.
    always_ff @(posedge lcd_pclk) begin
        if (take_c) begin
            lb1[addr_c] <= lb_mid_c;
            lb0[addr_c] <= in_data;
        end
    end

    // Per-channel min/max over all nine taps, then mode selection.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            taps_c[i]     = w_top[i];
            taps_c[i + 3] = w_mid[i];
            taps_c[i + 6] = w_bot[i];
        end
        op_data_c = '0;
        for (int k = 0; k < CH_N; k++) begin
            ch_min_c[k] = '1;
            ch_max_c[k] = '0;
            for (int j = 0; j < 9; j++) begin
                if (taps_c[j][k*CH_W +: CH_W] < ch_min_c[k]) begin
                    ch_min_c[k] = taps_c[j][k*CH_W +: CH_W];
                end
                if (taps_c[j][k*CH_W +: CH_W] > ch_max_c[k]) begin
                    ch_max_c[k] = taps_c[j][k*CH_W +: CH_W];
                end
            end
            case (mode_q)
                MODE_PASS:   op_data_c[k*CH_W +: CH_W] = w_mid[1][k*CH_W +: CH_W];
                MODE_ERODE:  op_data_c[k*CH_W +: CH_W] = ch_min_c[k];
                MODE_DILATE: op_data_c[k*CH_W +: CH_W] = ch_max_c[k];
                MODE_GRAD:   op_data_c[k*CH_W +: CH_W] = ch_max_c[k] - ch_min_c[k];
                default:     op_data_c[k*CH_W +: CH_W] = '0;
            endcase
        end
    end

    // Control FSM, counters, window shift and registered outputs.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            mode_q    <= MODE_PASS;
            err       <= 1'b0;
            win_vld   <= 1'b0;
            win_sof   <= 1'b0;
            win_eol   <= 1'b0;
            win_eof   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                w_top[i] <= '0;
                w_mid[i] <= '0;
                w_bot[i] <= '0;
            end
        end else begin
            win_vld <= win_ok_c;
            win_sof <= win_ok_c && (pos_row_c == CNT_W'(2)) && (pos_col_c == CNT_W'(2));
            win_eol <= win_ok_c && last_col_c;
            win_eof <= win_ok_c && last_pix_c;

            out_valid <= win_vld;
            out_sof   <= win_sof;
            out_eol   <= win_eol;
            out_eof   <= win_eof;
            if (win_vld) begin
                out_data <= op_data_c;
            end

            if (take_c) begin
                for (int i = 0; i < 2; i++) begin
                    w_top[i] <= w_top[i + 1];
                    w_mid[i] <= w_mid[i + 1];
                    w_bot[i] <= w_bot[i + 1];
                end
                w_top[2] <= lb_top_c;
                w_mid[2] <= lb_mid_c;
                w_bot[2] <= in_data;
                if (last_col_c) begin
                    col <= '0;
                    row <= pos_row_c + CNT_W'(1);
                end else begin
                    col <= pos_col_c + CNT_W'(1);
                    row <= pos_row_c;
                end
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_sof) begin
                            mode_q <= mode;
                            state  <= ACTIVE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (in_valid) begin
                        if (in_sof) begin
                            mode_q <= mode;
                            err    <= 1'b1;
                        end
                        // Frame complete: park counters so the next frame starts clean.
                        if (last_pix_c) begin
                            state <= IDLE;
                            col   <= '0;
                            row   <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
